// File: rtl/alu_sequencer.sv
//==============================================================================
// Module      : alu_sequencer
// Description : Fetch/decode/execute controller for an 8-bit CPU. It runs a
//               program from an external synchronous ROM and drives an
//               external combinational ALU. It owns a 4x8 register file, the
//               PC and a zero flag. One program runs per start pulse, up to
//               and including a HALT instruction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc_out,
    input  logic [15:0]     instr_in,
    output logic [7:0]      a_out,
    output logic [7:0]      b_out,
    output logic [2:0]      alu_sel_out,
    input  logic [7:0]      alu_result_in,
    output logic            zero_flag,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data
);

    // Instruction classes, taken from instr[15:14]
    localparam logic [1:0] C_ALU  = 2'b00;
    localparam logic [1:0] C_LDI  = 2'b01;
    localparam logic [1:0] C_BR   = 2'b10;
    localparam logic [1:0] C_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_instr;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [2:0]      r_sel;
    logic            r_zero;
    logic [7:0]      r_rf [4];

    // Fields of the instruction currently being executed
    logic [1:0]      w_cls;
    logic [1:0]      w_alu_rd;
    logic [1:0]      w_ldi_rd;
    logic [7:0]      w_imm;
    logic            w_br_cond;
    logic [PC_W-1:0] w_br_target;
    logic            w_br_taken;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_unused_instr;

    // Operand fields are read straight off the ROM bus during DECODE
    logic            w_dec_is_alu;
    logic [2:0]      w_dec_sel;
    logic [1:0]      w_dec_ra;
    logic [1:0]      w_dec_rb;

    assign w_cls          = r_instr[15:14];
    assign w_alu_rd       = r_instr[10:9];
    assign w_ldi_rd       = r_instr[13:12];
    assign w_imm          = r_instr[7:0];
    assign w_br_cond      = r_instr[13];
    assign w_br_target    = r_instr[PC_W-1:0];
    // Unconditional when cond=0, otherwise jump only on a set zero flag
    assign w_br_taken     = !w_br_cond || r_zero;
    // Plain modulo-2^PC_W increment: the top address wraps to zero
    assign w_pc_inc       = r_pc + PC_W'(1);
    // The low sel bit is only needed at DECODE, from the bus
    assign w_unused_instr = r_instr[11];

    assign w_dec_is_alu   = (instr_in[15:14] == C_ALU);
    assign w_dec_sel      = instr_in[13:11];
    assign w_dec_ra       = instr_in[8:7];
    assign w_dec_rb       = instr_in[6:5];

    assign pc_out         = r_pc;
    assign a_out          = r_a;
    assign b_out          = r_b;
    assign alu_sel_out    = r_sel;
    assign zero_flag      = r_zero;
    assign busy           = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                            (r_state == S_EXEC);
    assign done           = (r_state == S_DONE);
    assign dbg_data       = r_rf[dbg_sel];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: three cycles per instruction, DONE lasts one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = (w_cls == C_HALT) ? S_DONE : S_FETCH;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: PC, instruction latch, ALU operands, register file, flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= START_ADDR;
            r_instr <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_zero  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_pc <= START_ADDR;
                end
                S_DECODE: begin
                    r_instr <= instr_in;
                    // Operands are registered here so an ALU op may overwrite
                    // one of its own sources in EXEC
                    if (w_dec_is_alu) begin
                        r_a   <= r_rf[w_dec_ra];
                        r_b   <= r_rf[w_dec_rb];
                        r_sel <= w_dec_sel;
                    end
                end
                S_EXEC: begin
                    case (w_cls)
                        C_ALU: begin
                            r_rf[w_alu_rd] <= alu_result_in;
                            r_zero         <= (alu_result_in == 8'h00);
                            r_pc           <= w_pc_inc;
                        end
                        C_LDI: begin
                            r_rf[w_ldi_rd] <= w_imm;
                            r_pc           <= w_pc_inc;
                        end
                        C_BR: begin
                            r_pc <= w_br_taken ? w_br_target : w_pc_inc;
                        end
                        default: begin
                            // HALT leaves the PC on its own address
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none

module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;

    // Main DUT, START_ADDR = 0
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  pc_out;
    logic [15:0] instr;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_res;
    logic        zero_flag;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    // Second DUT, START_ADDR = 0xFF, used for the wrap scenario
    logic        start2;
    logic        busy2;
    logic        done2;
    logic [7:0]  pc_out2;
    logic [15:0] instr2;
    logic [7:0]  a_out2;
    logic [7:0]  b_out2;
    logic [2:0]  alu_sel2;
    logic [7:0]  alu_res2;
    logic        zero_flag2;
    logic [1:0]  dbg_sel2;
    logic [7:0]  dbg_data2;

    logic [15:0] rom  [256];
    logic [15:0] rom2 [256];

    int n_checks;
    int n_pass;

    localparam logic [15:0] HALT = 16'hC000;

    alu_sequencer #(.PC_W(8), .START_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pc_out(pc_out), .instr_in(instr), .a_out(a_out), .b_out(b_out),
        .alu_sel_out(alu_sel), .alu_result_in(alu_res), .zero_flag(zero_flag),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    alu_sequencer #(.PC_W(8), .START_ADDR(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .pc_out(pc_out2), .instr_in(instr2), .a_out(a_out2), .b_out(b_out2),
        .alu_sel_out(alu_sel2), .alu_result_in(alu_res2), .zero_flag(zero_flag2),
        .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: one cycle read latency
    always @(posedge clk) begin
        instr  <= rom[pc_out];
        instr2 <= rom2[pc_out2];
    end

    // ALU models: 000=ADD, 001=SUB, others AND
    always_comb begin
        case (alu_sel)
            3'b000:  alu_res = a_out + b_out;
            3'b001:  alu_res = a_out - b_out;
            default: alu_res = a_out & b_out;
        endcase
        case (alu_sel2)
            3'b000:  alu_res2 = a_out2 + b_out2;
            3'b001:  alu_res2 = a_out2 - b_out2;
            default: alu_res2 = a_out2 & b_out2;
        endcase
    end

    function automatic logic [15:0] f_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {2'b01, rd, 4'b0000, imm};
    endfunction

    function automatic logic [15:0] f_alu(input logic [2:0] sel, input logic [1:0] rd,
                                          input logic [1:0] ra, input logic [1:0] rb);
        return {2'b00, sel, rd, ra, rb, 5'b00000};
    endfunction

    function automatic logic [15:0] f_br(input logic cond, input logic [7:0] tgt);
        return {2'b10, cond, 5'b00000, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = HALT;
            rom2[i] = HALT;
        end
    endtask

    // Pulse start on the chosen DUT and count cycles (start cycle = 0) to done
    task automatic run_to_done(input bit second, output int n, output logic busy_first);
        if (second) start2 = 1'b1; else start = 1'b1;
        tick();
        if (second) start2 = 1'b0; else start = 1'b0;
        busy_first = second ? busy2 : busy;
        n = 1;
        while (((second ? done2 : done) !== 1'b1) && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: busy=%b done=%b, required 0/0", busy, done); else n_pass++;
        n_checks++; if (pc_out !== 8'h00) $display("FAIL reset_pc: got %h, required 00", pc_out); else n_pass++;
        n_checks++; if (pc_out2 !== 8'hFF) $display("FAIL reset_pc_start_ff: got %h, required ff", pc_out2); else n_pass++;
        n_checks++; if ({a_out, b_out, alu_sel, zero_flag} !== 20'h0) $display("FAIL reset_operands: a=%h b=%h sel=%h z=%b, required zeros", a_out, b_out, alu_sel, zero_flag); else n_pass++;
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'h00) $display("FAIL reset_r3: got %h, required 00", v); else n_pass++;
    endtask

    // Reset lands in the EXEC cycle of LDI r2,0x77 (third instruction)
    task automatic test_reset_mid_run();
        logic [7:0] v;
        clear_rom();
        rom[0] = f_ldi(2'd0, 8'h09);
        rom[1] = f_alu(3'b001, 2'd1, 2'd0, 2'd0);
        rom[2] = f_ldi(2'd2, 8'h77);
        rom[3] = HALT;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_checks++; if (a_out !== 8'h09 || zero_flag !== 1'b1) $display("FAIL pre_reset_state: a=%h z=%b, required 09/1", a_out, zero_flag); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pc_out !== 8'h00) $display("FAIL midrun_reset_ctrl: busy=%b done=%b pc=%h, required 0/0/00", busy, done, pc_out); else n_pass++;
        n_checks++; if ({a_out, b_out, alu_sel, zero_flag} !== 20'h0) $display("FAIL midrun_reset_operands: a=%h b=%h sel=%h z=%b, required zeros", a_out, b_out, alu_sel, zero_flag); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h00) $display("FAIL midrun_reset_r2: got %h, required 00", v); else n_pass++;
        read_reg(2'd0, v);
        n_checks++; if (v !== 8'h00) $display("FAIL midrun_reset_r0: got %h, required 00", v); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrun_reset_idle: busy=%b, required 0", busy); else n_pass++;
    endtask

    task automatic test_arith();
        int n;
        logic bf;
        logic [7:0] v;
        clear_rom();
        rom[0] = f_ldi(2'd0, 8'h05);
        rom[1] = f_ldi(2'd1, 8'h03);
        rom[2] = f_alu(3'b000, 2'd2, 2'd0, 2'd1);
        rom[3] = HALT;
        run_to_done(1'b0, n, bf);
        n_checks++; if (bf !== 1'b1) $display("FAIL arith_busy_first_fetch: got %b, required 1", bf); else n_pass++;
        n_checks++; if (n != 13) $display("FAIL arith_done_latency: got %0d cycles, required 13", n); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL arith_busy_in_done: got %b, required 0", busy); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL arith_done_one_cycle: got %b, required 0", done); else n_pass++;
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h08) $display("FAIL arith_r2: got %h, required 08", v); else n_pass++;
        n_checks++; if (zero_flag !== 1'b0) $display("FAIL arith_zero: got %b, required 0", zero_flag); else n_pass++;
        n_checks++; if (a_out !== 8'h05 || b_out !== 8'h03 || alu_sel !== 3'b000) $display("FAIL arith_operands_held: a=%h b=%h sel=%h, required 05/03/0", a_out, b_out, alu_sel); else n_pass++;
        n_checks++; if (pc_out !== 8'h03) $display("FAIL arith_halt_pc: got %h, required 03", pc_out); else n_pass++;
    endtask

    task automatic test_branch_taken();
        int n;
        logic seen_aa;
        logic [7:0] v;
        clear_rom();
        rom[0] = f_ldi(2'd0, 8'h07);
        rom[1] = f_alu(3'b001, 2'd1, 2'd0, 2'd0);
        rom[2] = f_br(1'b1, 8'h06);
        rom[3] = f_ldi(2'd3, 8'hAA);
        rom[4] = HALT;
        rom[6] = f_ldi(2'd3, 8'h55);
        rom[7] = HALT;
        dbg_sel = 2'd3;
        seen_aa = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            if (dbg_data === 8'hAA) seen_aa = 1'b1;
            tick();
            n++;
        end
        n_checks++; if (n != 16) $display("FAIL jz_done_latency: got %0d cycles, required 16", n); else n_pass++;
        n_checks++; if (seen_aa !== 1'b0) $display("FAIL jz_skipped_write: r3 saw aa=%b, required 0", seen_aa); else n_pass++;
        n_checks++; if (zero_flag !== 1'b1) $display("FAIL jz_zero: got %b, required 1", zero_flag); else n_pass++;
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'h55) $display("FAIL jz_r3: got %h, required 55", v); else n_pass++;
        n_checks++; if (pc_out !== 8'h07) $display("FAIL jz_halt_pc: got %h, required 07", pc_out); else n_pass++;
        tick();
    endtask

    task automatic test_branch_not_taken();
        int n;
        logic bf;
        logic [7:0] v;
        rom[1] = f_alu(3'b000, 2'd1, 2'd0, 2'd0);
        run_to_done(1'b0, n, bf);
        n_checks++; if (n != 16) $display("FAIL jnz_done_latency: got %0d cycles, required 16", n); else n_pass++;
        n_checks++; if (zero_flag !== 1'b0) $display("FAIL jnz_zero: got %b, required 0", zero_flag); else n_pass++;
        read_reg(2'd1, v);
        n_checks++; if (v !== 8'h0E) $display("FAIL jnz_r1: got %h, required 0e", v); else n_pass++;
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'hAA) $display("FAIL jnz_r3: got %h, required aa", v); else n_pass++;
        n_checks++; if (pc_out !== 8'h04) $display("FAIL jnz_halt_pc: got %h, required 04", pc_out); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        logic bf;
        rom2[8'hFF] = f_ldi(2'd0, 8'h01);
        rom2[8'h00] = HALT;
        run_to_done(1'b1, n, bf);
        n_checks++; if (n != 7 || done2 !== 1'b1) $display("FAIL wrap_done: got %0d cycles done=%b, required 7/1", n, done2); else n_pass++;
        n_checks++; if (pc_out2 !== 8'h00) $display("FAIL wrap_pc: got %h, required 00", pc_out2); else n_pass++;
        dbg_sel2 = 2'd0;
        #1;
        n_checks++; if (dbg_data2 !== 8'h01) $display("FAIL wrap_r0: got %h, required 01", dbg_data2); else n_pass++;
        tick();
    endtask

    // r0=7, r1=14 on entry; program is ADD r0=r0+r1; HALT
    task automatic test_start_while_busy();
        int n;
        logic bf;
        logic [7:0] v;
        clear_rom();
        rom[0] = f_alu(3'b000, 2'd0, 2'd0, 2'd1);
        rom[1] = HALT;
        start = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1 || pc_out !== 8'h00) $display("FAIL busy_start_fetch: busy=%b pc=%h, required 1/00", busy, pc_out); else n_pass++;
        repeat (3) tick();
        n_checks++; if (pc_out !== 8'h01) $display("FAIL busy_no_reload: pc=%h, required 01", pc_out); else n_pass++;
        repeat (3) tick();
        n_checks++; if (done !== 1'b1) $display("FAIL busy_done_pulse: got %b, required 1", done); else n_pass++;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL busy_idle_after_done: busy=%b done=%b, required 0/0", busy, done); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0 || pc_out !== 8'h01) $display("FAIL busy_no_restart: busy=%b pc=%h, required 0/01", busy, pc_out); else n_pass++;
        read_reg(2'd0, v);
        n_checks++; if (v !== 8'h15) $display("FAIL busy_first_run_r0: got %h, required 15", v); else n_pass++;
        run_to_done(1'b0, n, bf);
        n_checks++; if (n != 7) $display("FAIL rerun_latency: got %0d cycles, required 7", n); else n_pass++;
        read_reg(2'd0, v);
        n_checks++; if (v !== 8'h23) $display("FAIL rerun_r0: got %h, required 23", v); else n_pass++;
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'hAA) $display("FAIL rerun_r3_kept: got %h, required aa", v); else n_pass++;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        start    = 1'b0;
        start2   = 1'b0;
        dbg_sel  = 2'd0;
        dbg_sel2 = 2'd0;
        clear_rom();
        rst_n    = 1'b0;
        repeat (2) tick();
        rst_n    = 1'b1;
        tick();
        test_reset();
        test_reset_mid_run();
        test_arith();
        test_branch_taken();
        test_branch_not_taken();
        test_wrap();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
